proc_control_pipe: RTL and testbench
====================================

Name: proc_control_pipe

Overview:
Registered decode/control stage for the pipelined CPU, and successor to the single-cycle control wrapper. It decodes the instruction through the team's combinational decoder `control` and captures the result in an ID/EX control register. It adds stall, flush and valid qualification. It also adds a halt sequencer that drains the pipeline for a parametrised number of cycles before a one-cycle memory dump, then parks the core.

Parameters:
INSTR_W, 16, instruction width; must be >= 16. OpCode = instruction[INSTR_W-1:INSTR_W-5], Funct = instruction[1:0].
DRAIN_CYCLES, 3, cycles between halt acceptance and DMemDump; range 0..15.

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-high
instruction  in  INSTR_W  instruction from IF/ID
instr_valid  in  1  instruction is real (not a bubble)
stall  in  1  hold the control register and the drain counter
flush  in  1  squash: load a bubble; cancels a pending halt in DRAIN
RegDst  out  2  registered decode field
SESel  out  3  registered decode field
RegWrite, DMemWrite, DMemEn, ALUSrc2, PCSrc, PCImm, MemToReg, Jump  out  1 each  registered decode fields
DMemDump  out  1  one-cycle dump strobe from the halt sequencer
err  out  1  registered decoder error for the instruction in the register
err_sticky  out  1  set by any accepted err; cleared only by rst
ctrl_valid  out  1  register holds a real instruction
fetch_hold  out  1  freeze PC/fetch; high whenever state != RUN
halted  out  1  core parked

Behaviour:
- Reset (async, rst=1): all outputs 0, state RUN, drain counter 0.
- Decoder: one `control` instance, combinational path only. Its clk/rst pins are tied to clk/rst.
- Latency: 1 cycle from instruction to the control outputs.
- Register update priority, per rising edge:
  1. state DUMP or HALTED: load bubble (all fields 0, ctrl_valid 0).
  2. flush: load bubble. If state is DRAIN, go to RUN and clear the counter.
  3. stall: hold every register, including the counter.
  4. state RUN and instr_valid: load decoded fields, ctrl_valid=1, err=decoder err; err_sticky |= decoder err.
  5. otherwise: load bubble.
- Halt detection: decoder DMemDump=1 on an instruction accepted under rule 4.
  - The instruction is loaded with its registered DMemDump forced to 0.
  - If DRAIN_CYCLES > 0: state goes to DRAIN with counter = DRAIN_CYCLES-1.
  - If DRAIN_CYCLES = 0: state goes to DUMP.
- DRAIN: register loads bubbles; instr_valid is ignored. Each non-stall, non-flush cycle: counter==0 goes to DUMP, else the counter decrements.
- DUMP: DMemDump=1 for exactly one cycle, then HALTED.
- HALTED: halted=1, fetch_hold=1, bubbles; terminal until rst. flush, stall and instr_valid are ignored in DUMP and HALTED.
- A stall in the cycle that would enter DUMP delays DUMP. The DMemDump pulse is never held longer than 1 cycle.
- Simultaneous flush and a halt on the input in RUN: flush wins and the halt is not accepted.
- fetch_hold and halted are registered with state; fetch_hold is 1 in DRAIN, DUMP and HALTED.
- Reset mid-DRAIN or mid-DUMP: immediate return to the reset values. No dump pulse is emitted.
- Drain counter width: 4 bits.

Test Plan:
- Reset then NOP (opcode 5'b00001, instr_valid=1) → next cycle ctrl_valid=1, all control fields 0, DMemDump=0, fetch_hold=0.
- Halt (opcode 5'b00000) accepted at cycle T, DRAIN_CYCLES=3 → fetch_hold=1 from T+1; DMemDump=1 only at T+4; halted=1 from T+5.
- Same halt with stall=1 for 2 cycles during DRAIN → DMemDump shifts to T+6, still 1 cycle wide.
- Halt accepted, flush=1 at T+2 → state RUN at T+3, fetch_hold=0, no DMemDump; a following NOP gives ctrl_valid=1.
- stall=1 with new instruction present → outputs unchanged. flush=1 together with stall=1 → bubble (ctrl_valid=0).
- Illegal opcode with decoder err → err=1 for one cycle, err_sticky stays 1 until rst. rst asserted mid-DRAIN (DRAIN_CYCLES=0 variant also run) → all outputs 0 asynchronously.

Source files
------------

// File: rtl/proc_control_pipe.sv
// rtl/proc_control_pipe.sv - registered ID/EX control stage with halt drain/dump sequencer
module control (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] opcode,
    input  logic [1:0] funct,
    output logic [1:0] RegDst,
    output logic [2:0] SESel,
    output logic       RegWrite,
    output logic       DMemWrite,
    output logic       DMemEn,
    output logic       ALUSrc2,
    output logic       PCSrc,
    output logic       PCImm,
    output logic       MemToReg,
    output logic       DMemDump,
    output logic       Jump,
    output logic       err
);
    // Purely combinational; the clock/reset pins are kept only for drop-in compatibility.
    logic unused_pins;
    assign unused_pins = clk ^ rst;

    always_comb begin
        RegDst    = 2'b00;
        SESel     = 3'b000;
        RegWrite  = 1'b0;
        DMemWrite = 1'b0;
        DMemEn    = 1'b0;
        ALUSrc2   = 1'b0;
        PCSrc     = 1'b0;
        PCImm     = 1'b0;
        MemToReg  = 1'b0;
        DMemDump  = 1'b0;
        Jump      = 1'b0;
        err       = 1'b0;
        casez (opcode)
            5'b00000: DMemDump = 1'b1;
            5'b00001: ;
            5'b0100?: begin RegWrite = 1'b1; RegDst = 2'b01; ALUSrc2 = 1'b1; SESel = 3'b001; end
            5'b0101?: begin RegWrite = 1'b1; RegDst = 2'b01; ALUSrc2 = 1'b1; end
            5'b101??: begin RegWrite = 1'b1; RegDst = 2'b01; ALUSrc2 = 1'b1; end
            5'b10000: begin DMemEn = 1'b1; DMemWrite = 1'b1; ALUSrc2 = 1'b1; SESel = 3'b001; end
            5'b10001: begin
                DMemEn = 1'b1; MemToReg = 1'b1; RegWrite = 1'b1;
                RegDst = 2'b01; ALUSrc2 = 1'b1; SESel = 3'b001;
            end
            5'b10011: begin
                DMemEn = 1'b1; DMemWrite = 1'b1; RegWrite = 1'b1;
                RegDst = 2'b10; ALUSrc2 = 1'b1; SESel = 3'b001;
            end
            // BTR reserves every funct except 00.
            5'b11001: begin
                if (funct == 2'b00) RegWrite = 1'b1;
                else err = 1'b1;
            end
            5'b1101?: RegWrite = 1'b1;
            5'b111??: RegWrite = 1'b1;
            5'b011??: begin PCSrc = 1'b1; SESel = 3'b011; end
            5'b11000: begin RegWrite = 1'b1; RegDst = 2'b10; ALUSrc2 = 1'b1; SESel = 3'b011; end
            5'b10010: begin RegWrite = 1'b1; RegDst = 2'b10; ALUSrc2 = 1'b1; SESel = 3'b010; end
            5'b00100: begin Jump = 1'b1; PCImm = 1'b1; SESel = 3'b100; end
            5'b00101: begin Jump = 1'b1; SESel = 3'b011; end
            5'b00110: begin Jump = 1'b1; PCImm = 1'b1; RegWrite = 1'b1; RegDst = 2'b11; SESel = 3'b100; end
            5'b00111: begin Jump = 1'b1; RegWrite = 1'b1; RegDst = 2'b11; SESel = 3'b011; end
            default:  err = 1'b1;
        endcase
    end
endmodule

module proc_control_pipe #(
    parameter int INSTR_W      = 16,
    parameter int DRAIN_CYCLES = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [INSTR_W-1:0] instruction,
    input  logic               instr_valid,
    input  logic               stall,
    input  logic               flush,
    output logic [1:0]         RegDst,
    output logic [2:0]         SESel,
    output logic               RegWrite,
    output logic               DMemWrite,
    output logic               DMemEn,
    output logic               ALUSrc2,
    output logic               PCSrc,
    output logic               PCImm,
    output logic               MemToReg,
    output logic               Jump,
    output logic               DMemDump,
    output logic               err,
    output logic               err_sticky,
    output logic               ctrl_valid,
    output logic               fetch_hold,
    output logic               halted
);
    typedef enum logic [1:0] {RUN, DRAIN, DUMP, HALTED} state_t;

    localparam logic [3:0] DRAIN_LOAD = 4'((DRAIN_CYCLES > 0) ? DRAIN_CYCLES - 1 : 0);

    state_t      state, nxt_state;
    logic [3:0]  cnt, nxt_cnt;
    logic [12:0] fields, nxt_fields, dec_fields;
    logic        nxt_err, nxt_valid, nxt_sticky;
    logic [1:0]  dec_regdst;
    logic [2:0]  dec_sesel;
    logic        dec_regwrite, dec_dmemwrite, dec_dmemen, dec_alusrc2;
    logic        dec_pcsrc, dec_pcimm, dec_memtoreg, dec_jump, dec_dump, dec_err;
    logic        unused_bits;

    assign unused_bits = ^instruction[INSTR_W-6:2];

    control u_control (
        .clk       (clk),
        .rst       (rst),
        .opcode    (instruction[INSTR_W-1:INSTR_W-5]),
        .funct     (instruction[1:0]),
        .RegDst    (dec_regdst),
        .SESel     (dec_sesel),
        .RegWrite  (dec_regwrite),
        .DMemWrite (dec_dmemwrite),
        .DMemEn    (dec_dmemen),
        .ALUSrc2   (dec_alusrc2),
        .PCSrc     (dec_pcsrc),
        .PCImm     (dec_pcimm),
        .MemToReg  (dec_memtoreg),
        .DMemDump  (dec_dump),
        .Jump      (dec_jump),
        .err       (dec_err)
    );

    // The decoder's DMemDump is deliberately not carried in the register; the sequencer owns the strobe.
    assign dec_fields = {dec_regdst, dec_sesel, dec_regwrite, dec_dmemwrite, dec_dmemen,
                         dec_alusrc2, dec_pcsrc, dec_pcimm, dec_memtoreg, dec_jump};
    assign {RegDst, SESel, RegWrite, DMemWrite, DMemEn, ALUSrc2, PCSrc, PCImm, MemToReg, Jump} = fields;

    always_comb begin
        nxt_state  = state;
        nxt_cnt    = cnt;
        nxt_fields = 13'd0;
        nxt_err    = 1'b0;
        nxt_valid  = 1'b0;
        nxt_sticky = err_sticky;
        if (state == DUMP) begin
            nxt_state = HALTED;
        end else if (state == HALTED) begin
            nxt_state = HALTED;
        end else if (flush) begin
            if (state == DRAIN) begin
                nxt_state = RUN;
                nxt_cnt   = 4'd0;
            end
        end else if (stall) begin
            nxt_fields = fields;
            nxt_err    = err;
            nxt_valid  = ctrl_valid;
        end else if (state == RUN && instr_valid) begin
            nxt_fields = dec_fields;
            nxt_valid  = 1'b1;
            nxt_err    = dec_err;
            nxt_sticky = err_sticky | dec_err;
            if (dec_dump) begin
                if (DRAIN_CYCLES > 0) begin
                    nxt_state = DRAIN;
                    nxt_cnt   = DRAIN_LOAD;
                end else begin
                    nxt_state = DUMP;
                end
            end
        end else if (state == DRAIN) begin
            if (cnt == 4'd0) nxt_state = DUMP;
            else             nxt_cnt   = cnt - 4'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= RUN;
            cnt        <= 4'd0;
            fields     <= 13'd0;
            err        <= 1'b0;
            ctrl_valid <= 1'b0;
            err_sticky <= 1'b0;
            DMemDump   <= 1'b0;
            fetch_hold <= 1'b0;
            halted     <= 1'b0;
        end else begin
            state      <= nxt_state;
            cnt        <= nxt_cnt;
            fields     <= nxt_fields;
            err        <= nxt_err;
            ctrl_valid <= nxt_valid;
            err_sticky <= nxt_sticky;
            DMemDump   <= (nxt_state == DUMP);
            fetch_hold <= (nxt_state != RUN);
            halted     <= (nxt_state == HALTED);
        end
    end
endmodule

// File: tb/tb_proc_control_pipe.sv
// tb/tb_proc_control_pipe.sv - directed vector bench for proc_control_pipe
module tb_proc_control_pipe;
    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] instruction;
    logic        instr_valid, stall, flush;
    int          checks = 0;
    int          failures = 0;

    logic [1:0] a_regdst, b_regdst;
    logic [2:0] a_sesel, b_sesel;
    logic a_regwrite, a_dmemwrite, a_dmemen, a_alusrc2, a_pcsrc, a_pcimm, a_memtoreg, a_jump;
    logic a_dmemdump, a_err, a_err_sticky, a_ctrl_valid, a_fetch_hold, a_halted;
    logic b_regwrite, b_dmemwrite, b_dmemen, b_alusrc2, b_pcsrc, b_pcimm, b_memtoreg, b_jump;
    logic b_dmemdump, b_err, b_err_sticky, b_ctrl_valid, b_fetch_hold, b_halted;

    always #5 clk = ~clk;

    proc_control_pipe #(.INSTR_W(16), .DRAIN_CYCLES(3)) dut (
        .clk(clk), .rst(rst), .instruction(instruction), .instr_valid(instr_valid),
        .stall(stall), .flush(flush), .RegDst(a_regdst), .SESel(a_sesel),
        .RegWrite(a_regwrite), .DMemWrite(a_dmemwrite), .DMemEn(a_dmemen), .ALUSrc2(a_alusrc2),
        .PCSrc(a_pcsrc), .PCImm(a_pcimm), .MemToReg(a_memtoreg), .Jump(a_jump),
        .DMemDump(a_dmemdump), .err(a_err), .err_sticky(a_err_sticky), .ctrl_valid(a_ctrl_valid),
        .fetch_hold(a_fetch_hold), .halted(a_halted)
    );

    proc_control_pipe #(.INSTR_W(16), .DRAIN_CYCLES(0)) dut0 (
        .clk(clk), .rst(rst), .instruction(instruction), .instr_valid(instr_valid),
        .stall(stall), .flush(flush), .RegDst(b_regdst), .SESel(b_sesel),
        .RegWrite(b_regwrite), .DMemWrite(b_dmemwrite), .DMemEn(b_dmemen), .ALUSrc2(b_alusrc2),
        .PCSrc(b_pcsrc), .PCImm(b_pcimm), .MemToReg(b_memtoreg), .Jump(b_jump),
        .DMemDump(b_dmemdump), .err(b_err), .err_sticky(b_err_sticky), .ctrl_valid(b_ctrl_valid),
        .fetch_hold(b_fetch_hold), .halted(b_halted)
    );

    wire [12:0] a_fields = {a_regdst, a_sesel, a_regwrite, a_dmemwrite, a_dmemen,
                            a_alusrc2, a_pcsrc, a_pcimm, a_memtoreg, a_jump};
    wire [12:0] b_fields = {b_regdst, b_sesel, b_regwrite, b_dmemwrite, b_dmemen,
                            b_alusrc2, b_pcsrc, b_pcimm, b_memtoreg, b_jump};
    wire [2:0]  a_seq = {a_dmemdump, a_fetch_hold, a_halted};
    wire [18:0] a_all = {a_fields, a_err, a_err_sticky, a_ctrl_valid, a_seq};
    wire [18:0] b_all = {b_fields, b_err, b_err_sticky, b_ctrl_valid, b_dmemdump, b_fetch_hold, b_halted};

    typedef struct {
        logic [15:0] instr;
        logic        valid;
        logic        stl;
        logic        fl;
        logic [12:0] fields;
        logic        err;
        logic        cv;
        logic        sticky;
    } vec_t;

    vec_t vecs[16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        #2 rst = 1'b1;
        instruction = 16'h0800;
        instr_valid = 1'b0;
        stall = 1'b0;
        flush = 1'b0;
        #1;
        chk("reset_a_all", 32'(a_all), 32'd0);
        chk("reset_b_all", 32'(b_all), 32'd0);
        step();
        rst = 1'b0;
    endtask

    initial begin
        int dumps;
        rst = 1'b1;
        instruction = 16'h0800;
        instr_valid = 1'b0;
        stall = 1'b0;
        flush = 1'b0;
        #1;
        chk("por_a_all", 32'(a_all), 32'd0);
        step();
        rst = 1'b0;

        //           instr     v  s  f  fields                 err cv sticky
        vecs[0]  = '{16'h0800, 1, 0, 0, 13'b00_000_00000000, 0, 1, 0};
        vecs[1]  = '{16'h4000, 1, 0, 0, 13'b01_001_10010000, 0, 1, 0};
        vecs[2]  = '{16'h8800, 1, 0, 0, 13'b01_001_10110010, 0, 1, 0};
        vecs[3]  = '{16'h8000, 1, 0, 0, 13'b00_001_01110000, 0, 1, 0};
        vecs[4]  = '{16'h6000, 1, 0, 0, 13'b00_011_00001000, 0, 1, 0};
        vecs[5]  = '{16'h3000, 1, 0, 0, 13'b11_100_10000101, 0, 1, 0};
        vecs[6]  = '{16'hD801, 1, 0, 0, 13'b00_000_10000000, 0, 1, 0};
        vecs[7]  = '{16'h4000, 1, 1, 0, 13'b00_000_10000000, 0, 1, 0};
        vecs[8]  = '{16'h4000, 0, 0, 0, 13'b00_000_00000000, 0, 0, 0};
        vecs[9]  = '{16'h1000, 1, 0, 0, 13'b00_000_00000000, 1, 1, 1};
        vecs[10] = '{16'h0800, 1, 0, 0, 13'b00_000_00000000, 0, 1, 1};
        vecs[11] = '{16'h8800, 1, 1, 1, 13'b00_000_00000000, 0, 0, 1};
        vecs[12] = '{16'hC802, 1, 0, 0, 13'b00_000_00000000, 1, 1, 1};
        vecs[13] = '{16'h9800, 1, 0, 0, 13'b10_001_11110000, 0, 1, 1};
        vecs[14] = '{16'h2800, 1, 0, 0, 13'b00_011_00000001, 0, 1, 1};
        vecs[15] = '{16'hC000, 0, 1, 0, 13'b00_011_00000001, 0, 1, 1};

        for (int i = 0; i < 16; i++) begin
            instruction = vecs[i].instr;
            instr_valid = vecs[i].valid;
            stall = vecs[i].stl;
            flush = vecs[i].fl;
            step();
            chk($sformatf("vec%0d_fields", i), 32'(a_fields), 32'(vecs[i].fields));
            chk($sformatf("vec%0d_err", i), 32'(a_err), 32'(vecs[i].err));
            chk($sformatf("vec%0d_cv", i), 32'(a_ctrl_valid), 32'(vecs[i].cv));
            chk($sformatf("vec%0d_sticky", i), 32'(a_err_sticky), 32'(vecs[i].sticky));
            chk($sformatf("vec%0d_seq", i), 32'(a_seq), 32'd0);
            chk($sformatf("vec%0d_b_fields", i), 32'(b_fields), 32'(vecs[i].fields));
        end

        // Halt with drain of 3 (dut) and of 0 (dut0)
        do_reset();
        instruction = 16'h0000; instr_valid = 1'b1;
        step();
        chk("a_t1_fh", 32'(a_fetch_hold), 32'd1);
        chk("a_t1_cv", 32'(a_ctrl_valid), 32'd1);
        chk("a_t1_dump", 32'(a_dmemdump), 32'd0);
        chk("b_t1_dump", 32'(b_dmemdump), 32'd1);
        instruction = 16'h0800;
        step();
        chk("a_t2_dump", 32'(a_dmemdump), 32'd0);
        chk("a_t2_cv", 32'(a_ctrl_valid), 32'd0);
        chk("b_t2_dump", 32'(b_dmemdump), 32'd0);
        chk("b_t2_halted", 32'(b_halted), 32'd1);
        step();
        chk("a_t3_dump", 32'(a_dmemdump), 32'd0);
        step();
        chk("a_t4_seq", 32'(a_seq), 32'b110);
        step();
        chk("a_t5_seq", 32'(a_seq), 32'b011);
        flush = 1'b1; stall = 1'b1;
        step();
        chk("a_t6_seq", 32'(a_seq), 32'b011);
        chk("a_t6_cv", 32'(a_ctrl_valid), 32'd0);

        // Stall for two cycles during drain
        do_reset();
        instruction = 16'h0000; instr_valid = 1'b1;
        step();
        instruction = 16'h0800;
        stall = 1'b1;
        step();
        step();
        stall = 1'b0;
        chk("s_t3_dump", 32'(a_dmemdump), 32'd0);
        step();
        chk("s_t4_dump", 32'(a_dmemdump), 32'd0);
        step();
        chk("s_t5_dump", 32'(a_dmemdump), 32'd0);
        step();
        chk("s_t6_seq", 32'(a_seq), 32'b110);
        step();
        chk("s_t7_seq", 32'(a_seq), 32'b011);

        // Flush during drain cancels the halt
        do_reset();
        instruction = 16'h0000; instr_valid = 1'b1;
        step();
        instruction = 16'h0800;
        step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("f_t3_fh", 32'(a_fetch_hold), 32'd0);
        chk("f_t3_cv", 32'(a_ctrl_valid), 32'd0);
        step();
        chk("f_nop_cv", 32'(a_ctrl_valid), 32'd1);
        dumps = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            dumps += int'(a_dmemdump) + int'(a_fetch_hold);
        end
        chk("f_no_dump", 32'(dumps), 32'd0);

        // Flush together with a halt in RUN: halt not accepted
        do_reset();
        instruction = 16'h0000; instr_valid = 1'b1; flush = 1'b1;
        step();
        flush = 1'b0;
        instruction = 16'h0800;
        chk("fh_fh", 32'(a_fetch_hold), 32'd0);
        chk("fh_cv", 32'(a_ctrl_valid), 32'd0);
        dumps = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            dumps += int'(a_dmemdump) + int'(a_fetch_hold) + int'(b_dmemdump) + int'(b_fetch_hold);
        end
        chk("fh_no_dump", 32'(dumps), 32'd0);

        // Async reset mid-DRAIN (dut) and mid-DUMP (dut0)
        do_reset();
        instruction = 16'h0000; instr_valid = 1'b1;
        step();
        chk("r_a_fh", 32'(a_fetch_hold), 32'd1);
        chk("r_b_dump", 32'(b_dmemdump), 32'd1);
        instruction = 16'h0800;
        #2 rst = 1'b1;
        #1;
        chk("r_a_all", 32'(a_all), 32'd0);
        chk("r_b_all", 32'(b_all), 32'd0);
        step();
        rst = 1'b0;
        dumps = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            dumps += int'(a_dmemdump) + int'(b_dmemdump) + int'(a_fetch_hold) + int'(b_fetch_hold);
        end
        chk("r_no_dump", 32'(dumps), 32'd0);
        chk("r_cv", 32'(a_ctrl_valid), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
